// File: rtl/bin_to_bcd_if.sv
// Start/busy/done handshake and result bus between the address FSM and the BCD converter.
interface bin_to_bcd_if #(
  parameter int unsigned N_BITS = 11,
  parameter int unsigned DIGITS = 4
) ();
  logic                  start;
  logic [N_BITS-1:0]     bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// saturating to all nines when the value does not fit in DIGITS digits.
module bin_to_bcd_seq #(
  parameter int unsigned N_BITS = 11,
  parameter int unsigned DIGITS = 4
) (
  input logic        clk,
  input logic        rst,
  bin_to_bcd_if.slave bus
);
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + N_BITS;
  localparam int unsigned CntW = $clog2(N_BITS + 1);
  localparam logic [BcdW-1:0] Nines = {DIGITS{4'h9}};

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [SrW-1:0]    sr_q, sr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              flag_q, flag_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [SrW-1:0]    sr_adj;
  logic [SrW-1:0]    sr_shl;

  // Add-3 correction on every BCD digit in parallel, ahead of the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sr_q[N_BITS+4*i +: 4] >= 4'd5) begin
        sr_adj[N_BITS+4*i +: 4] = sr_q[N_BITS+4*i +: 4] + 4'd3;
      end
    end
    sr_shl = {sr_adj[SrW-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sr_d    = {{BcdW{1'b0}}, bus.bin_in};
          cnt_d   = '0;
          flag_d  = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d   = sr_shl;
        cnt_d  = cnt_q + CntW'(1);
        flag_d = flag_q | sr_adj[SrW-1];
        // Results land with the final shift so done and bcd_out share the DONE cycle.
        if (cnt_q == CntW'(N_BITS - 1)) begin
          state_d = StDone;
          done_d  = 1'b1;
          bcd_d   = flag_d ? Nines : sr_shl[SrW-1 -: BcdW];
          ovf_d   = flag_d;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: default 11-bit instance plus a 14-bit overflow instance.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_if #(.N_BITS(11), .DIGITS(4)) bus ();
  bin_to_bcd_if #(.N_BITS(14), .DIGITS(4)) wbus ();

  bin_to_bcd_seq #(.N_BITS(11), .DIGITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  bin_to_bcd_seq #(.N_BITS(14), .DIGITS(4)) dut_w (
    .clk(clk),
    .rst(rst),
    .bus(wbus)
  );

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One start pulse on the default instance; reports latency, busy cycles and hold behaviour.
  task automatic run_conv(input logic [10:0] val, output int lat, output int bcyc,
                          output bit got, output bit held);
    logic [15:0] prev;
    prev = bus.bcd_out;
    lat  = 0;
    bcyc = 0;
    got  = 1'b0;
    held = 1'b1;
    bus.start  = 1'b1;
    bus.bin_in = val;
    step;
    bus.start  = 1'b0;
    bus.bin_in = ~val;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) bcyc++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.bcd_out !== prev) held = 1'b0;
      step;
      lat++;
    end
    for (int i = 0; i < 40 && bus.busy; i++) begin
      step;
      if (bus.busy) bcyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.bcd_out !== 16'h0000) begin errors++; $display("FAIL reset_bcd got %h want 0000", bus.bcd_out); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    checks++; if (wbus.busy !== 1'b0) begin errors++; $display("FAIL reset_wide_busy got %b want 0", wbus.busy); end
  endtask

  task automatic test_zero;
    int lat, bcyc;
    bit got, held;
    run_conv(11'd0, lat, bcyc, got, held);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", got); end
    checks++; if (lat != 12) begin errors++; $display("FAIL zero_latency got %0d want 12", lat); end
    checks++; if (bcyc != 12) begin errors++; $display("FAIL zero_busy_cycles got %0d want 12", bcyc); end
    checks++; if (bus.bcd_out !== 16'h0000) begin errors++; $display("FAIL zero_bcd got %h want 0000", bus.bcd_out); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL zero_ovf got %b want 0", bus.ovf); end
  endtask

  task automatic test_back_to_back;
    int          acc[2];
    logic [15:0] res[2];
    logic        ov[2];
    int          nacc, ndone, cyc;
    bit          prev_busy, prev_done, dbl;
    acc = '{0, 0};
    res = '{16'hxxxx, 16'hxxxx};
    ov  = '{1'bx, 1'bx};
    nacc = 0; ndone = 0; cyc = 0; dbl = 1'b0;
    prev_busy = bus.busy;
    prev_done = bus.done;
    bus.bin_in = 11'd987;
    bus.start  = 1'b1;
    for (int i = 0; i < 60 && ndone < 2; i++) begin
      step;
      cyc++;
      if (bus.busy && !prev_busy) begin
        if (nacc < 2) acc[nacc] = cyc;
        nacc++;
        if (nacc == 1) bus.bin_in = 11'd2047;
        else bus.start = 1'b0;
      end
      if (bus.done) begin
        if (ndone < 2) begin
          res[ndone] = bus.bcd_out;
          ov[ndone]  = bus.ovf;
        end
        ndone++;
        if (prev_done) dbl = 1'b1;
      end
      prev_busy = bus.busy;
      prev_done = bus.done;
    end
    bus.start = 1'b0;
    step;
    checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
    checks++; if (acc[1] - acc[0] != 13) begin errors++; $display("FAIL b2b_spacing got %0d want 13", acc[1] - acc[0]); end
    checks++; if (res[0] !== 16'h0987) begin errors++; $display("FAIL b2b_first_bcd got %h want 0987", res[0]); end
    checks++; if (res[1] !== 16'h2047) begin errors++; $display("FAIL b2b_second_bcd got %h want 2047", res[1]); end
    checks++; if (ov[0] !== 1'b0 || ov[1] !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b%b want 00", ov[0], ov[1]); end
    checks++; if (dbl !== 1'b0) begin errors++; $display("FAIL b2b_done_width got double pulse want single"); end
  endtask

  task automatic test_ignore_start;
    int          e, ndone, done_at;
    logic [15:0] first_bcd;
    bit          late_busy;
    ndone = 0; done_at = -1; first_bcd = 16'hxxxx; late_busy = 1'b0;
    bus.start  = 1'b1;
    bus.bin_in = 11'd1234;
    step;
    e = 1;
    bus.start = 1'b0;
    step; step;
    e = 3;
    bus.start  = 1'b1;
    bus.bin_in = 11'd5;
    step;
    e = 4;
    bus.start  = 1'b0;
    bus.bin_in = 11'd0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) begin
        if (ndone == 0) begin
          done_at   = e;
          first_bcd = bus.bcd_out;
        end
        ndone++;
      end else if (ndone > 0 && bus.busy) begin
        late_busy = 1'b1;
      end
      step;
      e++;
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    checks++; if (done_at != 12) begin errors++; $display("FAIL ignore_latency got %0d want 12", done_at); end
    checks++; if (first_bcd !== 16'h1234) begin errors++; $display("FAIL ignore_bcd got %h want 1234", first_bcd); end
    checks++; if (late_busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued got busy after done want idle"); end
  endtask

  task automatic test_rst_mid;
    int lat, bcyc, ndone;
    bit got, held;
    bus.start  = 1'b1;
    bus.bin_in = 11'd1597;
    step;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.bcd_out !== 16'h0000) begin errors++; $display("FAIL rstmid_bcd got %h want 0000", bus.bcd_out); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", bus.done); end
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      step;
      if (bus.done) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", ndone); end
    run_conv(11'd1597, lat, bcyc, got, held);
    checks++; if (got !== 1'b1 || bus.bcd_out !== 16'h1597) begin
      errors++; $display("FAIL rstmid_reconvert got %h (done %b) want 1597", bus.bcd_out, got);
    end
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.bin_in = 11'd100;
    step;
    rst       = 1'b0;
    bus.start = 1'b0;
    step;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy got %b want 0", bus.busy); end
    checks++; if (bus.bcd_out !== 16'h0000) begin errors++; $display("FAIL rst_start_bcd got %h want 0000", bus.bcd_out); end
  endtask

  task automatic test_wide;
    logic [13:0] vals[2];
    logic [15:0] exp_bcd[2];
    logic        exp_ovf[2];
    int          lat;
    bit          got;
    vals    = '{14'd12345, 14'd9999};
    exp_bcd = '{16'h9999, 16'h9999};
    exp_ovf = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      wbus.start  = 1'b1;
      wbus.bin_in = vals[k];
      step;
      wbus.start  = 1'b0;
      wbus.bin_in = 14'd0;
      lat = 1;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (wbus.done) begin
          got = 1'b1;
          break;
        end
        step;
        lat++;
      end
      checks++; if (!got || lat != 15) begin errors++; $display("FAIL wide_latency[%0d] got %0d want 15", k, lat); end
      checks++; if (wbus.bcd_out !== exp_bcd[k]) begin errors++; $display("FAIL wide_bcd[%0d] got %h want %h", k, wbus.bcd_out, exp_bcd[k]); end
      checks++; if (wbus.ovf !== exp_ovf[k]) begin errors++; $display("FAIL wide_ovf[%0d] got %b want %b", k, wbus.ovf, exp_ovf[k]); end
      for (int i = 0; i < 5 && wbus.busy; i++) step;
    end
  endtask

  task automatic test_sweep;
    int lat, bcyc;
    bit got, held;
    for (int v = 0; v < 2048; v++) begin
      run_conv(11'(v), lat, bcyc, got, held);
      checks++; if (!got || bus.bcd_out !== ref_bcd(v) || bus.ovf !== 1'b0) begin
        errors++; $display("FAIL sweep_value[%0d] got %h ovf %b (done %b) want %h ovf 0", v, bus.bcd_out, bus.ovf, got, ref_bcd(v));
      end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL sweep_hold[%0d] got changed before done want held", v); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.bin_in  = '0;
    wbus.start  = 1'b0;
    wbus.bin_in = '0;
    test_reset;
    test_zero;
    test_back_to_back;
    test_ignore_start;
    test_rst_mid;
    test_wide;
    test_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
